// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_pkg : shared write-back selector encoding and load funct3 codes |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10
  } wb_sel_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_align : byte/half/word extraction with sign/zero extension      |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            fault
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = word[{addr, 3'b000} +: 8];
  assign w_half = word[{addr[1], 4'b0000} +: 16];

  always_comb begin
    data  = '0;
    fault = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU: data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH:  begin
        fault = addr[0];
        data  = {{(XLEN-16){w_half[15]}}, w_half};
      end
      F3_LHU: begin
        fault = addr[0];
        data  = {{(XLEN-16){1'b0}}, w_half};
      end
      F3_LW:  begin
        fault = (addr != 2'b00);
        data  = word;
      end
      default: fault = 1'b1;
    endcase
    // Faulting loads never leak partial data into the register file path
    if (fault) begin
      data = '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_wb_stage : MEM/WB pipeline register and write-back data select   |
// | Option       : WB_RETIRE_CNT_EN enables the retired-instruction count|
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module mem_wb_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_in,
  input  logic                  flush_in,
  input  logic                  valid_in,
  input  logic [XLEN-1:0]       pc_add4_in,
  input  logic [XLEN-1:0]       alu_result_in,
  input  logic [XLEN-1:0]       mem_data_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  reg_write_in,
  input  logic [1:0]            wb_sel_in,
  input  logic [2:0]            load_funct3_in,
  output logic [REG_ADDR_W-1:0] rd_wb,
  output logic                  reg_write_wb,
  output logic [XLEN-1:0]       write_data_WB,
  output logic                  valid_wb,
  output logic                  load_fault_wb,
  output logic [31:0]           retire_count
);
  import riscv_pkg::*;

  logic                  r_valid;
  logic                  r_reg_write;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [1:0]            r_wb_sel;
  logic [2:0]            r_funct3;
  logic [XLEN-1:0]       r_alu;
  logic [XLEN-1:0]       r_mem;
  logic [XLEN-1:0]       r_pc4;

  logic [XLEN-1:0]       w_load_data;
  logic                  w_align_fault;
  logic                  w_fault;

  // Flush only kills the control bits; the data fields are don't-care then
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_wb_sel    <= 2'b00;
      r_funct3    <= 3'b000;
      r_alu       <= '0;
      r_mem       <= '0;
      r_pc4       <= '0;
    end else if (flush_in) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (!stall_in) begin
      r_valid     <= valid_in;
      r_reg_write <= reg_write_in;
      r_rd        <= rd_in;
      r_wb_sel    <= wb_sel_in;
      r_funct3    <= load_funct3_in;
      r_alu       <= alu_result_in;
      r_mem       <= mem_data_in;
      r_pc4       <= pc_add4_in;
    end
  end

  load_align u_load_align (
    .word   (r_mem),
    .addr   (r_alu[1:0]),
    .funct3 (r_funct3),
    .data   (w_load_data),
    .fault  (w_align_fault)
  );

  assign w_fault = (r_wb_sel == WB_LOAD) && w_align_fault;

  always_comb begin
    write_data_WB = r_alu;
    case (r_wb_sel)
      WB_LOAD: write_data_WB = w_load_data;
      WB_PC4:  write_data_WB = r_pc4;
      default: write_data_WB = r_alu;
    endcase
  end

  assign rd_wb         = r_rd;
  assign valid_wb      = r_valid;
  assign reg_write_wb  = r_valid && r_reg_write && (r_rd != '0) && !w_fault;
  assign load_fault_wb = r_valid && w_fault;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] r_retire_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_retire_count <= '0;
    end else if (!flush_in && !stall_in && valid_in) begin
      r_retire_count <= r_retire_count + 32'd1;
    end
  end

  assign retire_count = r_retire_count;
`else
  assign retire_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_wb_stage : vector table, corner sequences and random compare  |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall_in, flush_in, valid_in, reg_write_in;
  logic [31:0] pc_add4_in, alu_result_in, mem_data_in;
  logic [4:0]  rd_in;
  logic [1:0]  wb_sel_in;
  logic [2:0]  load_funct3_in;
  logic [4:0]  rd_wb;
  logic        reg_write_wb, valid_wb, load_fault_wb;
  logic [31:0] write_data_WB, retire_count;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .pc_add4_in(pc_add4_in), .alu_result_in(alu_result_in),
    .mem_data_in(mem_data_in), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .wb_sel_in(wb_sel_in), .load_funct3_in(load_funct3_in), .rd_wb(rd_wb),
    .reg_write_wb(reg_write_wb), .write_data_WB(write_data_WB),
    .valid_wb(valid_wb), .load_fault_wb(load_fault_wb), .retire_count(retire_count)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        valid, rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu, mem, pc4;
  } instr_t;

  typedef struct {
    instr_t      in;
    logic [31:0] e_data;
    logic        e_rw, e_fault;
  } vec_t;

  instr_t      m;
  logic [31:0] m_cnt;
  vec_t        vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic v, input logic rw, input logic [4:0] rd,
                                input logic [1:0] sel, input logic [2:0] f3,
                                input logic [31:0] alu, input logic [31:0] mem,
                                input logic [31:0] pc4);
    instr_t x;
    x.valid = v; x.rw = rw; x.rd = rd; x.sel = sel; x.f3 = f3;
    x.alu = alu; x.mem = mem; x.pc4 = pc4;
    return x;
  endfunction

  function automatic vec_t mv(input instr_t x, input logic [31:0] d, input logic rw,
                              input logic f);
    vec_t v;
    v.in = x; v.e_data = d; v.e_rw = rw; v.e_fault = f;
    return v;
  endfunction

  // Reference load: pick the byte/half by shifting, extend arithmetically
  function automatic logic [31:0] ref_load(input instr_t x, output logic bad);
    int          off;
    logic [31:0] b, h, r;
    off = int'(x.alu[1:0]);
    b   = (x.mem >> (8 * off)) & 32'hFF;
    h   = (x.mem >> (16 * (off / 2))) & 32'hFFFF;
    bad = 1'b0;
    r   = 32'h0;
    case (x.f3)
      3'b000: r = (b >= 128) ? (b | 32'hFFFFFF00) : b;
      3'b100: r = b;
      3'b001: begin bad = (off % 2) != 0; r = (h >= 32768) ? (h | 32'hFFFF0000) : h; end
      3'b101: begin bad = (off % 2) != 0; r = h; end
      3'b010: begin bad = off != 0; r = x.mem; end
      default: bad = 1'b1;
    endcase
    return bad ? 32'h0 : r;
  endfunction

  task automatic drive(input instr_t x);
    valid_in = x.valid; reg_write_in = x.rw; rd_in = x.rd; wb_sel_in = x.sel;
    load_funct3_in = x.f3; alu_result_in = x.alu; mem_data_in = x.mem; pc_add4_in = x.pc4;
  endtask

  task automatic model_edge();
    if (reset) begin
      m = mk(0, 0, 0, 0, 0, 0, 0, 0);
      m_cnt = 0;
    end else if (flush_in) begin
      m.valid = 1'b0;
      m.rw = 1'b0;
    end else if (!stall_in) begin
      m = mk(valid_in, reg_write_in, rd_in, wb_sel_in, load_funct3_in,
             alu_result_in, mem_data_in, pc_add4_in);
      if (valid_in) m_cnt = m_cnt + 32'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model();
    logic        bad, is_ld;
    logic [31:0] ld, d;
    ld    = ref_load(m, bad);
    is_ld = (m.sel == 2'b01);
    d     = is_ld ? ld : (m.sel == 2'b10) ? m.pc4 : m.alu;
    chk("rnd_valid", {31'b0, valid_wb}, {31'b0, m.valid});
    chk("rnd_reg_write", {31'b0, reg_write_wb},
        {31'b0, m.valid && m.rw && (m.rd != 0) && !(is_ld && bad)});
    chk("rnd_fault", {31'b0, load_fault_wb}, {31'b0, m.valid && is_ld && bad});
    if (m.valid) begin
      chk("rnd_rd", {27'b0, rd_wb}, {27'b0, m.rd});
      chk("rnd_data", write_data_WB, d);
    end
`ifdef WB_RETIRE_CNT_EN
    chk("rnd_retire", retire_count, m_cnt);
`else
    chk("rnd_retire", retire_count, 32'h0);
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, {31'b0, valid_wb}, 32'h0);
    chk({tag, "_reg_write"}, {31'b0, reg_write_wb}, 32'h0);
    chk({tag, "_rd"}, {27'b0, rd_wb}, 32'h0);
    chk({tag, "_data"}, write_data_WB, 32'h0);
    chk({tag, "_fault"}, {31'b0, load_fault_wb}, 32'h0);
    chk({tag, "_retire"}, retire_count, 32'h0);
  endtask

  initial begin
    reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tick(); tick();
    check_zero("reset");
    reset = 1'b0;

    // Directed single-capture vectors
    vecs[0]  = mv(mk(1, 1, 5, 2'b01, 3'b000, 32'h103, 32'h80AABBCC, 0), 32'hFFFFFF80, 1, 0);
    vecs[1]  = mv(mk(1, 1, 5, 2'b01, 3'b100, 32'h103, 32'h80AABBCC, 0), 32'h00000080, 1, 0);
    vecs[2]  = mv(mk(1, 1, 5, 2'b01, 3'b001, 32'h101, 32'h80AABBCC, 0), 32'h0, 0, 1);
    vecs[3]  = mv(mk(1, 1, 6, 2'b01, 3'b101, 32'h102, 32'h80011234, 0), 32'h00008001, 1, 0);
    vecs[4]  = mv(mk(1, 1, 1, 2'b10, 3'b000, 32'h7, 0, 32'h48), 32'h48, 1, 0);
    vecs[5]  = mv(mk(1, 1, 0, 2'b10, 3'b000, 32'h7, 0, 32'h48), 32'h48, 0, 0);
    vecs[6]  = mv(mk(1, 1, 2, 2'b01, 3'b010, 32'h200, 32'hDEADBEEF, 0), 32'hDEADBEEF, 1, 0);
    vecs[7]  = mv(mk(1, 1, 2, 2'b01, 3'b010, 32'h202, 32'hDEADBEEF, 0), 32'h0, 0, 1);
    vecs[8]  = mv(mk(1, 1, 2, 2'b01, 3'b011, 32'h200, 32'hDEADBEEF, 0), 32'h0, 0, 1);
    vecs[9]  = mv(mk(1, 1, 7, 2'b00, 3'b011, 32'h12345678, 32'h1, 32'h4), 32'h12345678, 1, 0);
    vecs[10] = mv(mk(1, 1, 7, 2'b11, 3'b111, 32'hCAFEF00D, 32'h1, 32'h4), 32'hCAFEF00D, 1, 0);
    vecs[11] = mv(mk(1, 1, 8, 2'b01, 3'b000, 32'h301, 32'h80AABBCC, 0), 32'hFFFFFFBB, 1, 0);
    vecs[12] = mv(mk(1, 1, 8, 2'b01, 3'b001, 32'h300, 32'h80AA7BCC, 0), 32'h00007BCC, 1, 0);
    vecs[13] = mv(mk(1, 0, 9, 2'b00, 3'b000, 32'h55, 0, 0), 32'h55, 0, 0);
    vecs[14] = mv(mk(0, 1, 9, 2'b11, 3'b000, 32'h66, 0, 0), 32'h66, 0, 0);
    vecs[15] = mv(mk(1, 1, 4, 2'b01, 3'b110, 32'h0, 32'h12345678, 0), 32'h0, 0, 1);
    vecs[16] = mv(mk(0, 1, 4, 2'b01, 3'b001, 32'h3, 32'h12345678, 0), 32'h0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].in);
      tick();
      chk($sformatf("vec%0d_data", i), write_data_WB, vecs[i].e_data);
      chk($sformatf("vec%0d_reg_write", i), {31'b0, reg_write_wb}, {31'b0, vecs[i].e_rw});
      chk($sformatf("vec%0d_fault", i), {31'b0, load_fault_wb}, {31'b0, vecs[i].e_fault});
      chk($sformatf("vec%0d_valid", i), {31'b0, valid_wb}, {31'b0, vecs[i].in.valid});
      if (vecs[i].in.valid)
        chk($sformatf("vec%0d_rd", i), {27'b0, rd_wb}, {27'b0, vecs[i].in.rd});
    end

    // Reset mid-stream with a valid writing instruction presented
    drive(mk(1, 1, 3, 2'b00, 3'b000, 32'h55, 0, 0));
    reset = 1'b1;
    tick(); check_zero("midrst0");
    tick(); check_zero("midrst1");
    reset = 1'b0;
    check_zero("midrst_after");

    // Stall holds the captured instruction while inputs churn
    drive(mk(1, 1, 9, 2'b00, 3'b000, 32'hA5A50001, 0, 0));
    tick();
    chk("prestall_data", write_data_WB, 32'hA5A50001);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(mk(1, 1, 5'(i + 20), 2'b10, 3'b000, $urandom, $urandom, $urandom));
      tick();
      chk($sformatf("stall%0d_data", i), write_data_WB, 32'hA5A50001);
      chk($sformatf("stall%0d_rd", i), {27'b0, rd_wb}, 32'd9);
      chk($sformatf("stall%0d_reg_write", i), {31'b0, reg_write_wb}, 32'h1);
      chk($sformatf("stall%0d_valid", i), {31'b0, valid_wb}, 32'h1);
    end
    flush_in = 1'b1;
    tick();
    chk("flushstall_valid", {31'b0, valid_wb}, 32'h0);
    chk("flushstall_reg_write", {31'b0, reg_write_wb}, 32'h0);
    flush_in = 1'b0; stall_in = 1'b0;

`ifdef WB_RETIRE_CNT_EN
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      flush_in = (i == 3) || (i == 8);
      stall_in = (i == 5) || (i == 10) || (i == 12);
      drive(mk(1, 1, 5'(i + 1), 2'b00, 3'b000, 32'(i), 0, 0));
      tick();
    end
    flush_in = 1'b0; stall_in = 1'b0;
    chk("retire_ten", retire_count, 32'd10);
    @(negedge clk);
    force dut.r_retire_count = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.r_retire_count;
    drive(mk(1, 1, 1, 2'b00, 3'b000, 32'h1, 0, 0));
    tick();
    chk("retire_wrap", retire_count, 32'h0);
    m_cnt = 32'h0;
`endif

    // Randomised traffic against the reference model
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 49) == 0);
      flush_in = ($urandom_range(0, 9) == 0);
      stall_in = ($urandom_range(0, 6) == 0);
      drive(mk(1'($urandom), 1'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
               2'($urandom), 3'($urandom), $urandom, $urandom, $urandom));
      tick();
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register and write-back stage. Sits directly downstream of the MEM stage and captures its ALU result/address, data-memory read word, PC+4 and control fields. Performs load byte/half extraction and sign/zero extension. Produces the register-file write port and the write_data_WB value that the MEM stage forwards into its store-data path.

Parameters:
XLEN, 32, datapath width (only 32 supported)
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
stall_in  in  1  hold stage contents
flush_in  in  1  replace incoming instruction with bubble
valid_in  in  1  MEM-stage instruction valid
pc_add4_in  in  32  PCadd4 from MEM stage
alu_result_in  in  32  ALU result / data-memory address
mem_data_in  in  32  word read from data memory (D_out), valid same cycle as address
rd_in  in  5  destination register
reg_write_in  in  1  instruction writes rd
wb_sel_in  in  2  00 ALU, 01 load, 10 PC+4, 11 ALU
load_funct3_in  in  3  load type (RV32I funct3)
rd_wb  out  5  registered destination
reg_write_wb  out  1  qualified register-file write enable
write_data_WB  out  32  write-back value (also fed to MEM store-data mux)
valid_wb  out  1  stage holds a valid instruction
load_fault_wb  out  1  misaligned or reserved-funct3 load in stage
retire_count  out  32  retired-instruction counter (see Optional Feature)

Behaviour:
- Reset values: all internal registers and all outputs are 0; write_data_WB=0.
- Edge priority, per rising edge: reset > flush_in > stall_in > capture.
- Capture: all *_in fields are registered; latency is 1 cycle from MEM inputs to WB outputs.
- flush_in=1: valid and reg_write registers are cleared and the data fields are don't-care. flush_in overrides a simultaneous stall_in.
- stall_in=1 (no flush): all registers hold. Outputs are stable and reg_write_wb stays asserted if it was asserted; a repeated register-file write of the same value is harmless.
- Load extraction is combinational from registered fields, in sub-module load_align. off = addr[1:0].
  - LB/LBU: byte mem[8*off+7:8*off], sign- or zero-extended.
  - LH/LHU: half mem[16*addr[1]+15:16*addr[1]], sign- or zero-extended.
  - LW: full word.
- Fault when wb_sel=01 and any of:
  - LH/LHU with addr[0]=1;
  - LW with addr[1:0]!=0;
  - funct3 in {011, 110, 111}.
  - On a fault: load_fault_wb=1, load data forced to 0, reg_write_wb=0.
- write_data_WB mux: 00/11 alu_result, 01 extracted load data, 10 pc_add4.
- reg_write_wb = valid & reg_write & (rd!=0) & !load_fault.
- load_fault_wb = valid & fault condition.
- valid_wb = registered valid.
- No handshake beyond stall/flush. Upstream guarantees that mem_data_in corresponds to alu_result_in in the capture cycle.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined: 32-bit counter, reset to 0, increments on every edge where the stage captures (no reset, no flush, no stall) and valid_in=1. Wraps 0xFFFFFFFF -> 0. Faulting loads still count.
- Not defined: retire_count is tied to 0 and no counter logic is synthesised.

Decomposition:
- Package riscv_pkg holds:
  - wb_sel_t enum (WB_ALU=2'b00, WB_LOAD=2'b01, WB_PC4=2'b10);
  - load funct3 constants F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101;
  - XLEN.
- One combinational sub-module, load_align: inputs word, addr[1:0], funct3; outputs data and fault.

Test Plan:
- Reset mid-stream, with valid_in=1 and reg_write_in=1 presented during reset -> all outputs 0 during and 1 cycle after reset; retire_count=0.
- LB at addr 0x103, mem=0x80AABBCC, rd=5 -> next cycle write_data_WB=0xFFFFFF80, rd_wb=5, reg_write_wb=1. Same with LBU -> 0x00000080.
- LH at addr 0x101 -> load_fault_wb=1, reg_write_wb=0, write_data_WB=0. LHU at addr 0x102, mem=0x8001_1234 -> 0x00008001.
- wb_sel=10, pc_add4=0x00000048, rd=1 -> write_data_WB=0x48. Same instruction with rd=0 -> reg_write_wb=0, valid_wb=1.
- Stall for 3 cycles while the inputs change -> outputs frozen at the pre-stall values. Assert flush_in and stall_in together -> next cycle valid_wb=0, reg_write_wb=0.
- With WB_RETIRE_CNT_EN defined: 10 valid captures, 2 flushed and 3 stalled cycles interleaved -> retire_count=10. Preload the counter to 0xFFFFFFFF via a forced start, then 1 capture -> retire_count=0.
